// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: FSM states, Rcon, S-boxes and GF(2^8) arithmetic.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    KEYEXP = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    return (idx < 4'd10) ? RCON[idx] : 8'h00;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] m;
    p = '0;
    x = a;
    m = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (m[0]) p ^= x;
      x = xtime(x);
      m = m >> 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns when mix is set.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         mix,
  output logic [127:0] state_out
);

  logic [127:0] keyed;
  logic [127:0] mixed;

  for (genvar c = 0; c < 4; c++) begin : g_col
    // Row r rotates right by r columns, so destination column c reads from c-r.
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC = 4 * ((c + 4 - r) % 4) + r;
      localparam int DST = 4 * c + r;
      assign keyed[127-8*DST -: 8] = inv_sbox(state_in[127-8*SRC -: 8])
                                     ^ round_key[127-8*DST -: 8];
    end

    logic [7:0] a0, a1, a2, a3;
    assign a0 = keyed[127-32*c -: 8];
    assign a1 = keyed[119-32*c -: 8];
    assign a2 = keyed[111-32*c -: 8];
    assign a3 = keyed[103-32*c -: 8];

    assign mixed[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                                ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
    assign mixed[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                                ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
    assign mixed[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                                ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
    assign mixed[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                                ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
  end

  always_comb begin
    state_out = mix ? mixed : keyed;
  end

endmodule

// File: rtl/aes128_dec_iter.sv
// Iterative AES-128 decryptor: forward key expansion to rk10, then ten inverse
// rounds that unwind the key schedule on the fly from a single key register.
module aes128_dec_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  state_t       fsm;
  logic [3:0]   cnt;
  logic [127:0] rk;
  logic [127:0] st;
  logic [127:0] rk_fwd;
  logic [127:0] rk_inv;
  logic [127:0] round_out;
  logic         mix;

  function automatic logic [31:0] key_g(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  always_comb begin
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] p0, p1, p2, p3;
    f0 = rk[127:96] ^ key_g(rk[31:0], rcon(cnt));
    f1 = rk[95:64] ^ f0;
    f2 = rk[63:32] ^ f1;
    f3 = rk[31:0] ^ f2;
    rk_fwd = {f0, f1, f2, f3};
    // Inverse step: recover words 3..1 by XOR of neighbours, then word 0 via g().
    p3 = rk[31:0] ^ rk[63:32];
    p2 = rk[63:32] ^ rk[95:64];
    p1 = rk[95:64] ^ rk[127:96];
    p0 = rk[127:96] ^ key_g(p3, rcon(cnt));
    rk_inv = {p0, p1, p2, p3};
    mix = (cnt != 4'd0);
  end

  aes_inv_round u_round (
    .state_in  (st),
    .round_key (rk_inv),
    .mix       (mix),
    .state_out (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= IDLE;
      cnt       <= '0;
      rk        <= '0;
      st        <= '0;
      plaintext <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            rk       <= key;
            st       <= ciphertext;
            cnt      <= '0;
            fsm      <= KEYEXP;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        KEYEXP: begin
          // Ten schedule steps, then one cycle folding rk10 into the ciphertext.
          if (cnt == 4'd10) begin
            st  <= st ^ rk;
            cnt <= 4'd9;
            fsm <= ROUND;
          end else begin
            rk  <= rk_fwd;
            cnt <= cnt + 4'd1;
          end
        end
        ROUND: begin
          st <= round_out;
          rk <= rk_inv;
          if (cnt == 4'd0) begin
            plaintext <= round_out;
            out_valid <= 1'b1;
            fsm       <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_dec_iter.sv
// Bench for aes128_dec_iter: known-answer table, handshake/reset sequences and
// random pairs generated by an independent forward AES model.
module tb_aes128_dec_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;

  aes128_dec_iter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb [256];

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mul(input int a, input int b);
    int p = 0;
    int x = a;
    int y = b;
    while (y != 0) begin
      if ((y & 1) != 0) p ^= x;
      x = x << 1;
      if ((x & 256) != 0) x ^= 'h11b;
      y = y >> 1;
    end
    return 8'(p);
  endfunction

  function automatic int rotl8(input int v, input int k);
    return ((v << k) | (v >> (8 - k))) & 255;
  endfunction

  // S-box from first principles: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      int inv = 0;
      int s;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (mul(x, y) == 8'd1) inv = y;
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 'h63;
      sb[x] = 8'(s);
    end
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] rc = 8'h01;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
    for (int i = 16; i < 176; i += 4) begin
      logic [7:0] tmp [4];
      for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
      if (i % 16 == 0) begin
        tmp = '{sb[w[i-3]] ^ rc, sb[w[i-2]], sb[w[i-1]], sb[w[i-4]]};
        rc = mul(int'(rc), 2);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[4*(((i/4) + (i%4)) % 4) + i%4]];
      if (r < 10)
        for (int c = 0; c < 4; c++) begin
          logic [7:0] a0, a1, a2, a3;
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = mul(a0, 2) ^ mul(a1, 3) ^ a2 ^ a3;
          t[4*c+1] = a0 ^ mul(a1, 2) ^ mul(a2, 3) ^ a3;
          t[4*c+2] = a0 ^ a1 ^ mul(a2, 2) ^ mul(a3, 3);
          t[4*c+3] = mul(a0, 3) ^ a1 ^ a2 ^ mul(a3, 2);
        end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[16*r+i];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Called #1 after a rising edge with the DUT idle; returns at the same phase
  // after the result has been accepted.
  task automatic run_op(input logic [127:0] k, input logic [127:0] c,
                        output logic [127:0] pt, output int lat);
    key = k;
    ciphertext = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    key = rand128();
    ciphertext = rand128();
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check("busy_during_op", {in_ready, busy}, 128'd1);
    end
    pt = plaintext;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t kat [2];
    logic [127:0] got;
    logic [127:0] exp_pt;
    logic [127:0] k;
    int lat;

    kat[0] = '{128'h000102030405060708090a0b0c0d0e0f,
               128'h69c4e0d86a7b0430d8cdb78070b4c55a,
               128'h00112233445566778899aabbccddeeff};
    kat[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'h3925841d02dc09fbdc118597196a0b32,
               128'h3243f6a8885a308d313198a2e0370734};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    key = '0;
    ciphertext = '0;
    build_sbox();

    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_plaintext", plaintext, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", in_ready, 1);

    for (int i = 0; i < 2; i++) begin
      run_op(kat[i].key, kat[i].ct, got, lat);
      check($sformatf("kat%0d_pt", i), got, kat[i].pt);
      check($sformatf("kat%0d_latency", i), lat, 21);
      check($sformatf("kat%0d_idle", i), {in_ready, out_valid, busy}, 128'b100);
    end

    // Consumer stalls five cycles while a new pair is offered.
    key = kat[1].key;
    ciphertext = kat[1].ct;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("stall_latency", lat, 21);
    in_valid = 1'b1;
    key = rand128();
    ciphertext = rand128();
    for (int i = 0; i < 5; i++) begin
      check("stall_pt", plaintext, kat[1].pt);
      check("stall_flags", {out_valid, in_ready}, 128'b10);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall_release", {in_ready, out_valid, busy}, 128'b100);

    // Second offer mid-operation must be ignored.
    key = kat[0].key;
    ciphertext = kat[0].ct;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat == 4) begin
        in_valid = 1'b1;
        key = kat[1].key;
        ciphertext = kat[1].ct;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("ignore_latency", lat, 21);
    check("ignore_pt", plaintext, kat[0].pt);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ignore_no_queue", {in_ready, out_valid, busy}, 128'b100);

    // Reset in the middle of the round phase.
    key = kat[0].key;
    ciphertext = kat[0].ct;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_flags", {out_valid, busy}, 128'b00);
    check("midreset_plaintext", plaintext, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midreset_in_ready", in_ready, 1);
    run_op(kat[0].key, kat[0].ct, got, lat);
    check("post_reset_pt", got, kat[0].pt);
    check("post_reset_latency", lat, 21);

    for (int n = 0; n < 1000; n++) begin
      k = rand128();
      exp_pt = rand128();
      run_op(k, encrypt(k, exp_pt), got, lat);
      check($sformatf("rand%0d_pt", n), got, exp_pt);
      check($sformatf("rand%0d_latency", n), lat, 21);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
